// File: rtl/csel_pipe_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csel_pipe_adder_if                                           |
// | Description : Operand/result valid-ready bundle for csel_pipe_adder.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface csel_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
    logic             ovf_out;

    modport master (
        output valid_in, a_in, b_in, c_in, ready_in,
        input  ready_out, valid_out, s_out, c_out, ovf_out
    );

    modport slave (
        input  valid_in, a_in, b_in, c_in, ready_in,
        output ready_out, valid_out, s_out, c_out, ovf_out
    );
endinterface
`default_nettype wire

// File: rtl/csel_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csel_pipe_adder                                              |
// | Description : Two-stage pipelined carry-select adder on 4-bit slices,      |
// |               valid/ready handshake on both sides.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csel_pipe_adder #(
    parameter int WIDTH = 32
) (
    input  wire                     clk_in,
    input  wire                     rst_in,
    csel_pipe_adder_if.slave        io
);

    localparam int N = WIDTH / 4;

    function automatic logic [4:0] f_slice_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
        return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    endfunction

    // Carry into bit 3 of a slice, needed for the overflow term of the top slice.
    function automatic logic f_carry3(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
        logic [3:0] t;
        t = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        return t[3];
    endfunction

    logic w_adv1, w_adv2;

    logic                 r_v1;
    logic [3:0]           r_s0;
    logic                 r_co0;
    logic [N-1:1][3:0]    r_sum0, r_sum1;
    logic [N-1:1]         r_cy0, r_cy1;
    logic                 r_msbc0, r_msbc1;

    logic                 r_v2;
    logic [WIDTH-1:0]     r_s;
    logic                 r_co;
    logic                 r_ovf;

    logic [3:0]           w_s0;
    logic                 w_co0;
    logic [N-1:1][3:0]    w_sum0, w_sum1;
    logic [N-1:1]         w_cy0, w_cy1;
    logic                 w_msbc0, w_msbc1;

    logic [N-1:0]         w_c;
    logic [N-1:1][3:0]    w_sel;
    logic                 w_msbc;

    assign w_adv2       = !r_v2 || io.ready_in;
    assign w_adv1       = !r_v1 || w_adv2;
    assign io.ready_out = w_adv1;
    assign io.valid_out = r_v2;
    assign io.s_out     = r_s;
    assign io.c_out     = r_co;
    assign io.ovf_out   = r_ovf;

    always_comb begin
        w_sum0 = '0;
        w_sum1 = '0;
        w_cy0  = '0;
        w_cy1  = '0;
        {w_co0, w_s0} = f_slice_add(io.a_in[3:0], io.b_in[3:0], io.c_in);
        for (int k = 1; k < N; k++) begin
            {w_cy0[k], w_sum0[k]} = f_slice_add(io.a_in[4*k +: 4], io.b_in[4*k +: 4], 1'b0);
            {w_cy1[k], w_sum1[k]} = f_slice_add(io.a_in[4*k +: 4], io.b_in[4*k +: 4], 1'b1);
        end
        w_msbc0 = f_carry3(io.a_in[WIDTH-1 -: 4], io.b_in[WIDTH-1 -: 4], 1'b0);
        w_msbc1 = f_carry3(io.a_in[WIDTH-1 -: 4], io.b_in[WIDTH-1 -: 4], 1'b1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_v1    <= 1'b0;
            r_s0    <= '0;
            r_co0   <= 1'b0;
            r_sum0  <= '0;
            r_sum1  <= '0;
            r_cy0   <= '0;
            r_cy1   <= '0;
            r_msbc0 <= 1'b0;
            r_msbc1 <= 1'b0;
        end else if (w_adv1) begin
            r_v1    <= io.valid_in;
            r_s0    <= w_s0;
            r_co0   <= w_co0;
            r_sum0  <= w_sum0;
            r_sum1  <= w_sum1;
            r_cy0   <= w_cy0;
            r_cy1   <= w_cy1;
            r_msbc0 <= w_msbc0;
            r_msbc1 <= w_msbc1;
        end
    end

    // Carry chain resolved by selection: one mux level per slice boundary.
    always_comb begin
        w_c   = '0;
        w_sel = '0;
        w_c[0] = r_co0;
        for (int k = 1; k < N; k++) begin
            w_c[k]   = w_c[k-1] ? r_cy1[k]  : r_cy0[k];
            w_sel[k] = w_c[k-1] ? r_sum1[k] : r_sum0[k];
        end
        w_msbc = w_c[N-2] ? r_msbc1 : r_msbc0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_v2  <= 1'b0;
            r_s   <= '0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_adv2) begin
            r_v2  <= r_v1;
            r_s   <= {w_sel, r_s0};
            r_co  <= w_c[N-1];
            r_ovf <= w_c[N-1] ^ w_msbc;
        end
    end

endmodule
`default_nettype wire
